// File: rtl/spi_pkg.sv
// Shared types and sizes for the mode-0 SPI master.
package spi_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BIT_CNT_W  = 4;
    localparam int TIMER_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/sclk_phase_timer.sv
// Loadable down-counter that times the CS setup, SCLK half-periods and CS hold.
module sclk_phase_timer
    import spi_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               expire_o
);

    logic [TIMER_W-1:0] cnt_q;

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0, MSB first, with programmable CS setup/hold.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4,
    parameter int unsigned CS_SETUP    = 2,
    parameter int unsigned CS_HOLD     = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [DATA_WIDTH-1:0] TXDataLine,
    input  logic                  MISO,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic                  _CS,
    output logic [DATA_WIDTH-1:0] RXDataLine,
    output logic                  Busy,
    output logic                  TranscationCompleted
);

    // Timer loads are N-1 because the phase ends on the cycle the counter reads zero.
    localparam logic [TIMER_W-1:0]   SETUP_LOAD = TIMER_W'(CS_SETUP - 1);
    localparam logic [TIMER_W-1:0]   HALF_LOAD  = TIMER_W'(HALF_PERIOD - 1);
    localparam logic [TIMER_W-1:0]   HOLD_LOAD  = TIMER_W'(CS_HOLD - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(DATA_WIDTH - 1);

    spi_state_e state_q, state_d;

    logic                  tmr_load;
    logic [TIMER_W-1:0]    tmr_val;
    logic                  tmr_expire;

    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    sclk_phase_timer u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE:  if (Start)      begin state_d = SETUP; tmr_load = 1'b1; tmr_val = SETUP_LOAD; end
            SETUP: if (tmr_expire) begin state_d = LOW;   tmr_load = 1'b1; tmr_val = HALF_LOAD;  end
            LOW:   if (tmr_expire) begin state_d = HIGH;  tmr_load = 1'b1; tmr_val = HALF_LOAD;  end
            HIGH: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = HOLD;
                        tmr_val = HOLD_LOAD;
                    end else begin
                        state_d = LOW;
                        tmr_val = HALF_LOAD;
                    end
                end
            end
            HOLD:  if (tmr_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    tx_d      = TXDataLine;
                    mosi_d    = TXDataLine[DATA_WIDTH-1];
                    bit_cnt_d = '0;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SETUP: if (tmr_expire) sclk_d = 1'b0;
            LOW: begin
                if (tmr_expire) begin
                    sclk_d  = 1'b1;
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], MISO};
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // The last bit stays on MOSI through HOLD.
                    if (bit_cnt_q != LAST_BIT) begin
                        tx_d   = {tx_q[DATA_WIDTH-2:0], tx_q[DATA_WIDTH-1]};
                        mosi_d = tx_q[DATA_WIDTH-2];
                    end
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SCLK                 = sclk_q;
    assign MOSI                 = mosi_q;
    assign _CS                  = cs_n_q;
    assign RXDataLine           = rx_data_q;
    assign Busy                 = busy_q;
    assign TranscationCompleted = done_q;

endmodule
